multiplier_arbiter_5: RTL and testbench

Round-robin arbiter and sequencer that shares one instance of the structural 5x5 signed multiplier, multiplier_signed_5, among NUM_REQ requesters. It grants one requester at a time, registers the operands into the shared multiplier and registers the settled 10-bit product. It then presents the result, tagged with the requester index, on a single response channel with valid/ready backpressure. It sits between the multiply clients and the downstream consumer of products.

---
 rtl/multiplier_arbiter_5.sv | 191 +++++++++++++++++++
 tb/tb_multiplier_arbiter_5.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_arbiter_5.sv
// -----------------------------------------------------------------------------
// multiplier_arbiter_5
//
// Shares one structural 5x5 signed multiplier among NUM_REQ requesters.
// One requester is granted at a time. Its operands are registered into the
// shared multiplier, and the settled product is registered. The result is
// then presented, tagged with the requester index, on a single valid/ready
// response channel.
//
// Sequence per transaction: IDLE (grant + operand capture) -> MUL (product
// capture) -> RESP (hold until rsp_ready). Best case is one product per
// 3 cycles.
//
// Build option:
//   MULT_ARB_FIXED_PRIORITY_EN  defined   -> the lowest index with
//                                            req_valid=1 always wins; no
//                                            round-robin pointer exists.
//                               undefined -> round-robin starting at rr_ptr
//                                            (default build).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]    per-requester operand valid
//   req_ready  out  [NUM_REQ]    per-requester grant/accept, one-hot or zero
//   req_a      in   [5*NUM_REQ]  signed multiplicands, requester i at [5i+4:5i]
//   req_b      in   [5*NUM_REQ]  signed multipliers, same packing
//   rsp_valid  out  product valid
//   rsp_ready  in   consumer accepts product
//   rsp_p      out  [10]         signed product A*B
//   rsp_id     out  [ID_W]       index of the requester that issued the product
//   busy       out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------

// Structural 5x5 signed multiplier built from shifted partial products. The
// multiplier's MSB carries weight -16, so its partial product is subtracted.
// All sums wrap in 10 bits, and the true result always fits.
module multiplier_signed_5 (
    input  logic signed [4:0] i_a,
    input  logic signed [4:0] i_b,
    output logic signed [9:0] o_p
);

    logic signed [9:0] w_a_ext;
    logic signed [9:0] w_pp [5];

    assign w_a_ext = {{5{i_a[4]}}, i_a};

    for (genvar gi = 0; gi < 5; gi++) begin : g_pp
        assign w_pp[gi] = i_b[gi] ? (w_a_ext <<< gi) : 10'sd0;
    end

    assign o_p = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3] - w_pp[4];

endmodule

module multiplier_arbiter_5 #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [5*NUM_REQ-1:0] req_a,
    input  logic [5*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic signed [9:0]    rsp_p,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic signed [4:0]   r_op_a;
    logic signed [4:0]   r_op_b;
    logic [ID_W-1:0]     r_id_q;
    logic signed [9:0]   r_rsp_p;
    logic [ID_W-1:0]     r_rsp_id;

    logic                w_gnt_found;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_hs;
    logic signed [9:0]   w_prod;

    // Index base+k reduced modulo NUM_REQ: the requester visited k steps
    // after base in the circular search.
    function automatic logic [ID_W-1:0] wrap_idx(input int base, input int k);
        return ID_W'((base + k) % NUM_REQ);
    endfunction

`ifndef MULT_ARB_FIXED_PRIORITY_EN
    logic [ID_W-1:0]     r_rr_ptr;
`endif

    // Search for the first requesting index. In round-robin mode the search
    // starts at rr_ptr and wraps; in fixed-priority mode it starts at 0.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIORITY_EN
            if (!w_gnt_found && req_valid[wrap_idx(0, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = wrap_idx(0, k);
            end
`else
            if (!w_gnt_found && req_valid[wrap_idx(int'(r_rr_ptr), k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = wrap_idx(int'(r_rr_ptr), k);
            end
`endif
        end
    end

    // A grant is only offered while idle and out of reset. Masking with
    // reset_n keeps req_ready low even though the state register already
    // reads IDLE during reset.
    assign w_hs = reset_n && (r_state == S_IDLE) && w_gnt_found;

    always_comb begin
        req_ready = '0;
        if (w_hs) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_state_nxt = S_MUL;
            S_MUL:   w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_id_q   <= '0;
            r_rsp_p  <= '0;
            r_rsp_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Operands are sampled only on the handshake edge.
            if (w_hs) begin
                r_op_a <= req_a[5*int'(w_gnt_idx) +: 5];
                r_op_b <= req_b[5*int'(w_gnt_idx) +: 5];
                r_id_q <= w_gnt_idx;
            end
            // The multiplier has had a full cycle to settle from r_op_a/r_op_b.
            if (r_state == S_MUL) begin
                r_rsp_p  <= w_prod;
                r_rsp_id <= r_id_q;
            end
        end
    end

`ifndef MULT_ARB_FIXED_PRIORITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= wrap_idx(int'(w_gnt_idx), 1);
        end
    end
`endif

    multiplier_signed_5 u_mul (
        .i_a (r_op_a),
        .i_b (r_op_b),
        .o_p (w_prod)
    );

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_p     = r_rsp_p;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_multiplier_arbiter_5.sv
module tb_multiplier_arbiter_5;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [5*N-1:0] req_a;
    logic [5*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic signed [9:0] rsp_p;
    logic [1:0]     rsp_id;
    logic           busy;

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level reference: who is next in line, and the one product
    // owed to the consumer.
    int         m_ptr;
    bit         m_pending;
    int         m_age;      // cycles since the accepting edge
    logic [9:0] m_exp_p;
    int         m_exp_id;

    logic [9:0] last_p;
    int         last_id;
    bit         got_rsp;
    int         cyc;
    int         gnt_q[$];
    int         gnt_cyc[$];

    always #5 clk = ~clk;

    multiplier_arbiter_5 #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // First requester at or after the fairness pointer (or lowest index in
    // the fixed-priority build).
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int i;
`ifdef MULT_ARB_FIXED_PRIORITY_EN
            i = k;
`else
            i = (m_ptr + k) % N;
`endif
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_op(input int idx, input int a, input int b);
        req_a[5*idx +: 5] = a[4:0];
        req_b[5*idx +: 5] = b[4:0];
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_p"}, $unsigned(rsp_p), 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic step_check();
        logic [N-1:0] e_ready;
        bit           e_valid;
        int           g;
        int           sa;
        int           sb;
        int           prod;
        e_ready = '0;
        e_valid = 1'b0;
        g       = -1;
        if (!m_pending) begin
            g = pick(req_valid);
            if (g >= 0) e_ready[g] = 1'b1;
        end else if (m_age >= 2) begin
            e_valid = 1'b1;
        end
        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, e_valid);
        chk("busy", busy, m_pending);
        if (e_valid) begin
            chk("rsp_p", $unsigned(rsp_p), m_exp_p);
            chk("rsp_id", rsp_id, m_exp_id);
        end
        if (g >= 0) begin
            sa        = $signed(req_a[5*g +: 5]);
            sb        = $signed(req_b[5*g +: 5]);
            prod      = sa * sb;
            m_exp_p   = prod[9:0];
            m_exp_id  = g;
            m_ptr     = (g + 1) % N;
            m_pending = 1'b1;
            m_age     = 0;
            gnt_q.push_back(g);
            gnt_cyc.push_back(cyc);
        end else if (e_valid && rsp_ready) begin
            last_p    = rsp_p;
            last_id   = rsp_id;
            got_rsp   = 1'b1;
            m_pending = 1'b0;
        end
        if (m_pending) m_age++;
    endtask

    // Inputs are set after a rising edge, checked on the falling edge and
    // clocked on the next rising edge.
    task automatic tick();
        @(negedge clk);
        step_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && m_pending; i++) tick();
        chk("drain_idle", m_pending, 0);
    endtask

    task automatic run_one(input string tag, input int idx, input int a, input int b,
                           input logic [9:0] expp);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        set_op(idx, a, b);
        rsp_ready = 1'b1;
        got_rsp   = 1'b0;
        tick();
        req_valid = '0;
        for (int i = 0; i < 10 && !got_rsp; i++) tick();
        chk({tag, "_seen"}, got_rsp, 1);
        chk({tag, "_p"}, last_p, expp);
        chk({tag, "_id"}, last_id, idx);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int exp_order[5];
        reset_n   = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        m_ptr     = 0;
        m_pending = 1'b0;
        m_age     = 0;
        m_exp_p   = '0;
        m_exp_id  = 0;
        last_p    = '0;
        last_id   = 0;
        got_rsp   = 1'b0;
        cyc       = 0;

        // Reset held for 3 cycles with every requester asserting.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_chk("reset");
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // All requesters continuously valid: rotation order and spacing.
`ifdef MULT_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        gnt_q.delete();
        gnt_cyc.delete();
        req_valid = '1;
        for (int i = 0; i < 13; i++) begin
            req_a = 20'($urandom());
            req_b = 20'($urandom());
            tick();
        end
        chk("rr_count_ge5", gnt_q.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < gnt_q.size()) chk("rr_order", gnt_q[i], exp_order[i]);
            if (i > 0 && i < gnt_q.size()) chk("rr_gap", gnt_cyc[i] - gnt_cyc[i-1], 3);
        end
        drain();

        // Single request and corner products.
        run_one("single", 1, -3, 7, 10'h3EB);
        run_one("m16m16", 0, -16, -16, 10'h100);
        run_one("m16p15", 3, -16, 15, 10'h310);
        run_one("zero", 2, 0, -16, 10'h000);
        run_one("p15p15", 1, 15, 15, 10'h0E1);

        // Backpressure with operands scrambled after the grant.
        req_valid = 4'b0100;
        set_op(2, 9, -5);
        rsp_ready = 1'b0;
        got_rsp   = 1'b0;
        tick();
        req_valid = 4'($urandom_range(0, 15));
        req_a     = 20'($urandom());
        req_b     = 20'($urandom());
        tick();
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_a     = 20'($urandom());
            req_b     = 20'($urandom());
            tick();
        end
        chk("bp_held", got_rsp, 0);
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 5 && !got_rsp; i++) tick();
        chk("bp_seen", got_rsp, 1);
        chk("bp_p", last_p, 10'h3D3);
        chk("bp_id", last_id, 2);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_a     = 20'($urandom());
            req_b     = 20'($urandom());
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset while in MUL: in-flight product is discarded.
        req_valid = 4'b1000;
        set_op(3, 5, 5);
        rsp_ready = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        rst_chk("midrst");
        m_pending = 1'b0;
        m_ptr     = 0;
        @(posedge clk);
        #1;
        rst_chk("midrst_hold");
        reset_n   = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) tick();
        gnt_q.delete();
        gnt_cyc.delete();
        req_valid = '1;
        tick();
        chk("postrst_gnt_seen", gnt_q.size(), 1);
        if (gnt_q.size() > 0) chk("postrst_gnt_idx", gnt_q[0], 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
